// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the line-buffer window chain: accepts a raster stream,
// drives the shift enable, tracks row/col, flushes with padding and pulses done.
module line_buffer_ctrl #(
  parameter int DEPTH  = 10,
  parameter int ROWS   = 10,
  parameter int KERNEL = 9
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic                                   pixel_valid_i,
  output logic                                   pixel_ready_o,
  output logic                                   shift_en_o,
  output logic                                   pad_o,
  output logic                                   window_valid_o,
  output logic [$clog2(DEPTH)-1:0]               col_o,
  output logic [$clog2(ROWS+(KERNEL-1)/2)-1:0]   row_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int H  = (KERNEL - 1) / 2;
  localparam int CW = $clog2(DEPTH);
  localparam int RW = $clog2(ROWS + H);

  localparam logic [CW-1:0] COL_LAST       = CW'(DEPTH - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FLUSH_LAST = RW'(ROWS + H - 1);
  localparam logic [RW-1:0] ROW_CENTRE     = RW'(H);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;

  logic col_last;
  logic row_centred;

  assign col_last    = (col_q == COL_LAST);
  assign row_centred = (row_q >= ROW_CENTRE);

  // Strobes decoded from registered state; pixel_valid_i only passes one AND.
  assign pixel_ready_o  = (state_q == FILL);
  assign pad_o          = (state_q == FLUSH);
  assign busy_o         = (state_q != IDLE);
  assign shift_en_o     = (pixel_ready_o & pixel_valid_i) | pad_o;
  assign window_valid_o = shift_en_o & row_centred;
  assign col_o          = col_q;
  assign row_o          = row_q;
  assign done_o         = done_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = FILL;
            col_d   = '0;
            row_d   = '0;
          end
        end
        FILL: begin
          if (pixel_valid_i) begin
            if (col_last) begin
              col_d = '0;
              row_d = row_q + RW'(1);
              if (row_q == ROW_FILL_LAST) begin
                state_d = FLUSH;
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        FLUSH: begin
          if (col_last) begin
            col_d = '0;
            // Last padded shift: leave counters at 0 so row never overruns.
            if (row_q == ROW_FLUSH_LAST) begin
              state_d = DONE;
              row_d   = '0;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: two parameter sets, randomized valid patterns,
// checked every cycle against a pixel-count reference model.
module tb_line_buffer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic pixel_valid_i = 1'b0;

  always #5 clk = ~clk;

  logic       a_ready, a_shift, a_pad, a_wv, a_busy, a_done;
  logic [3:0] a_col, a_row;
  logic       b_ready, b_shift, b_pad, b_wv, b_busy, b_done;
  logic [2:0] b_col, b_row;

  line_buffer_ctrl #(.DEPTH(10), .ROWS(10), .KERNEL(9)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pixel_valid_i(pixel_valid_i), .pixel_ready_o(a_ready), .shift_en_o(a_shift),
    .pad_o(a_pad), .window_valid_o(a_wv), .col_o(a_col), .row_o(a_row),
    .busy_o(a_busy), .done_o(a_done));

  line_buffer_ctrl #(.DEPTH(5), .ROWS(4), .KERNEL(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pixel_valid_i(pixel_valid_i), .pixel_ready_o(b_ready), .shift_en_o(b_shift),
    .pad_o(b_pad), .window_valid_o(b_wv), .col_o(b_col), .row_o(b_row),
    .busy_o(b_busy), .done_o(b_done));

  int   sel = 0;
  logic o_ready, o_shift, o_pad, o_wv, o_busy, o_done;
  int   o_col, o_row;

  always_comb begin
    if (sel == 0) begin
      o_ready = a_ready; o_shift = a_shift; o_pad = a_pad; o_wv = a_wv;
      o_busy = a_busy; o_done = a_done; o_col = int'(a_col); o_row = int'(a_row);
    end else begin
      o_ready = b_ready; o_shift = b_shift; o_pad = b_pad; o_wv = b_wv;
      o_busy = b_busy; o_done = b_done; o_col = int'(b_col); o_row = int'(b_row);
    end
  end

  localparam int M_IDLE = 0, M_FILL = 1, M_FLUSH = 2, M_DONE = 3;

  int D, R, H;
  int m_mode, m_k;
  bit m_clr;
  int cyc;
  int n_acc, last_acc, done_cyc;
  int st_wv, st_flush, st_done, st_first_acc, st_first_row, st_first_col;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; last_acc = -1; done_cyc = -1;
    st_wv = 0; st_flush = 0; st_done = 0;
    st_first_acc = -1; st_first_row = -1; st_first_col = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_shift"}, o_shift, 0);
    chk({tag, "_pad"},   o_pad,   0);
    chk({tag, "_wv"},    o_wv,    0);
    chk({tag, "_busy"},  o_busy,  0);
    chk({tag, "_done"},  o_done,  0);
    chk({tag, "_col"},   o_col,   0);
    chk({tag, "_row"},   o_row,   0);
  endtask

  // One clock: drive at posedge+1, check at negedge, update the model at posedge.
  task automatic cycle(input logic st, input logic ab, input logic pv);
    logic e_shift;
    int   e_row, e_col;
    start_i = st; abort_i = ab; pixel_valid_i = pv;
    #4;
    e_shift = (m_mode == M_FILL && pv) || (m_mode == M_FLUSH);
    e_row   = (m_mode == M_IDLE) ? 0 : m_k / D;
    e_col   = (m_mode == M_IDLE) ? 0 : m_k % D;
    chk("ready", o_ready, int'(m_mode == M_FILL));
    chk("pad",   o_pad,   int'(m_mode == M_FLUSH));
    chk("busy",  o_busy,  int'(m_mode != M_IDLE));
    chk("done",  o_done,  int'(m_mode == M_DONE));
    chk("shift", o_shift, int'(e_shift));
    chk("wv",    o_wv,    int'(e_shift && e_row >= H));
    if (m_mode == M_FILL || m_mode == M_FLUSH || (m_mode == M_IDLE && m_clr)) begin
      chk("row", o_row, e_row);
      chk("col", o_col, e_col);
    end
    if (o_pad) st_flush++;
    if (o_wv) begin
      st_wv++;
      if (st_first_acc < 0) begin
        st_first_acc = n_acc + 1; st_first_row = o_row; st_first_col = o_col;
      end
    end
    if (o_done) begin st_done++; done_cyc = cyc; end
    if (m_mode == M_FILL && pv && !ab) begin n_acc++; last_acc = cyc; end
    @(posedge clk);
    cyc++;
    if (ab) begin
      m_mode = M_IDLE; m_k = 0; m_clr = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE:  if (st) begin m_mode = M_FILL; m_k = 0; m_clr = 1'b0; end
        M_FILL:  if (pv) begin m_k++; if (m_k == D * R) m_mode = M_FLUSH; end
        M_FLUSH: begin m_k++; if (m_k == D * (R + H)) m_mode = M_DONE; end
        default: m_mode = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; pixel_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1;
    m_mode = M_IDLE; m_k = 0; m_clr = 1'b1;
    clear_stats();
  endtask

  // pat: 0 continuous, 1 alternating starting with a gap, 2 random.
  task automatic run_frame(input int pat, input bit poke, input int abort_at, output int len);
    int   guard, cyc0;
    logic pv, st, ab, tog;
    clear_stats();
    cyc0 = cyc; guard = 0; tog = 1'b0; len = 0;
    cycle(1'b1, 1'b0, 1'b0);
    while (m_mode != M_IDLE && guard < 4000) begin
      case (pat)
        0:       pv = 1'b1;
        1:       begin pv = tog; tog = ~tog; end
        default: pv = ($urandom_range(99) < 60);
      endcase
      st = poke && ($urandom_range(5) == 0);
      ab = (abort_at >= 0) && (n_acc == abort_at) && (m_mode == M_FILL);
      cycle(st, ab, pv);
      guard++;
    end
    chk("frame_terminates", int'(guard < 4000), 1);
    if (abort_at < 0) begin
      chk("wv_pulses",    st_wv,    D * R);
      chk("flush_cycles", st_flush, H * D);
      chk("done_count",   st_done,  1);
      chk("done_latency", done_cyc - last_acc, H * D + 1);
      chk("first_wv_acc", st_first_acc, H * D + 1);
      chk("first_wv_row", st_first_row, H);
      chk("first_wv_col", st_first_col, 0);
      len = done_cyc - cyc0;
    end else begin
      chk("abort_no_done", st_done, 0);
      chk("abort_accepts", n_acc, abort_at);
    end
  endtask

  initial begin
    int len_c, len_a, len_x, guard;
    cyc = 0;

    sel = 0; D = 10; R = 10; H = 4;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    run_frame(0, 1'b0, -1, len_c);
    run_frame(1, 1'b0, -1, len_a);
    chk("alt_done_delay", len_a - len_c, D * R);
    run_frame(2, 1'b1, -1, len_x);
    run_frame(2, 1'b1, -1, len_x);

    run_frame(2, 1'b0, 57, len_x);
    cycle(1'b0, 1'b0, 1'b1);
    run_frame(0, 1'b0, -1, len_x);

    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    sel = 1; D = 5; R = 4; H = 1;
    do_reset();
    run_frame(0, 1'b0, -1, len_x);
    run_frame(2, 1'b1, -1, len_x);

    // Asynchronous reset in the middle of the flush.
    clear_stats();
    cycle(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(m_mode == M_FLUSH && m_k == D * R + 2) && guard < 500) begin
      cycle(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("reach_flush", int'(guard < 500), 1);
    start_i = 1'b0; pixel_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_mode = M_IDLE; m_k = 0; m_clr = 1'b1;
    st_done = 0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("async_rst_no_done", st_done, 0);
    run_frame(0, 1'b0, -1, len_x);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Frame sequencer for the 9-row line-buffer window chain. It accepts a raster pixel stream, generates the shift enable for the line buffers, and tracks the row/column of the newest pixel. It flags which shifts produce a window centred on a real pixel. At end of frame it flushes the chain with zero-padded pixels so the bottom rows reach the window centre, then pulses done. It sits between the pixel source and the line-buffer chain and replaces the free-running done-extension counter.

## Interface
- DEPTH, 10: pixels per line (line-buffer depth), ≥ 2
- ROWS, 10: lines per frame, ≥ KERNEL
- KERNEL, 9: window height, odd, ≥ 3; H = (KERNEL-1)/2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  frame start pulse
- abort_i  in  1  synchronous abort, returns to IDLE without done
- pixel_valid_i  in  1  source has a pixel on the data bus
- pixel_ready_o  out  1  controller accepts a pixel this cycle
- shift_en_o  out  1  advance every line buffer by one pixel
- pad_o  out  1  datapath must inject 8'd0 instead of source data
- window_valid_o  out  1  this shift yields a window centred on a real pixel
- col_o  out  $clog2(DEPTH)  column of the pixel entering this cycle
- row_o  out  $clog2(ROWS+H)  row of the pixel entering this cycle; flush rows included
- busy_o  out  1  high in FILL, FLUSH or DONE
- done_o  out  1  one-cycle end-of-frame pulse

## Operation
- States: IDLE, FILL, FLUSH, DONE. Reset state is IDLE with col = row = 0.
- IDLE:
  - pixel_ready_o = shift_en_o = pad_o = 0.
  - start_i moves to FILL and clears col and row.
- FILL:
  - pixel_ready_o = 1 and shift_en_o = pixel_valid_i.
  - On each accept, col increments. At DEPTH-1, col wraps to 0 and row increments.
  - No accept means a stall: counters hold and shift_en_o = 0.
  - An accept at row = ROWS-1, col = DEPTH-1 moves to FLUSH, with col → 0 and row → ROWS.
- FLUSH:
  - pixel_ready_o = 0, shift_en_o = 1, pad_o = 1 every cycle. Counters advance as in FILL.
  - Lasts exactly H*DEPTH cycles. The cycle at row = ROWS+H-1, col = DEPTH-1 is the last; it moves to DONE.
- DONE:
  - All strobes are 0; done_o = 1 for this single cycle. Next state is IDLE.
- window_valid_o = shift_en_o & (row_o ≥ H). The window centre is (row_o-H, col_o).
  - Exactly DEPTH*ROWS window_valid pulses occur per frame.
- start_i is ignored outside IDLE.
- abort_i has priority over every transition. From any state it goes to IDLE, clears counters, and produces no done_o. abort_i and start_i together in IDLE means stay in IDLE.
- Arithmetic is unsigned. The row counter never exceeds ROWS+H-1; the column counter never exceeds DEPTH-1.

## Timing
- State, col, row and done_o are registered.
- pixel_ready_o, pad_o and busy_o are decoded from the registered state only.
- shift_en_o and window_valid_o are combinational from state, counters and pixel_valid_i. The path from pixel_valid_i to output is a single AND level.
- Reset values: all outputs 0; col_o = row_o = 0.
- Reset asserted mid-frame forces IDLE immediately (asynchronously). No done_o is produced.
- Latency:
  - start_i at edge N: FILL from cycle N+1, so pixel_ready_o is high in cycle N+1.
  - Last source accept at cycle M: FLUSH runs M+1 .. M+H*DEPTH, done_o is high at M+H*DEPTH+1, and busy_o falls at M+H*DEPTH+2.
- Handshake: a transfer occurs iff pixel_valid_i & pixel_ready_o at the rising edge. The source may hold valid low for any number of cycles.
- Back-to-back frames: start_i may arrive in the first IDLE cycle after done_o.

## Test plan
- Default params, start_i, then 100 continuous valid pixels:
  - first window_valid_o on accept #41, at row_o = 4, col_o = 0.
  - 40 FLUSH cycles with pad_o = 1.
  - 100 window_valid pulses total.
  - done_o exactly once, 41 cycles after the last accept.
- Same frame with pixel_valid_i toggling 1-0-1-0:
  - counters and shift_en_o hold on gaps.
  - identical row/col sequence and pulse count; done_o 100 cycles later than the continuous case.
- Wrap check:
  - accept at col 9, row 2 → next col_o = 0, row_o = 3.
  - final accept at row 9, col 9 → next cycle pad_o = 1, row_o = 10, col_o = 0.
- start_i pulsed during FILL and FLUSH → ignored; no counter reset, one done_o.
- abort_i at pixel 57 → IDLE next cycle, counters 0, no done_o. A fresh start_i afterwards runs a full correct frame.
- rst_n low mid-FLUSH → outputs 0 asynchronously, no done_o. KERNEL = 3, ROWS = 4, DEPTH = 5 → 5 flush cycles and 20 window_valid pulses.
